// File: rtl/pipe_stage_buffer.sv
// Generic valid/ready pipeline register with an optional 2-entry skid buffer.
// An empty stage drives BUBBLE_VAL, so downstream logic that ignores valid sees a NOP.
module pipe_stage_buffer #(
    parameter int unsigned       DATA_W     = 96,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter bit                SKID_EN    = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready;
    logic              in_fire;
    logic              out_fire;

    always_comb begin
        // With the skid entry, ready depends only on held state, breaking the ready path.
        if (SKID_EN) begin
            in_ready = (state_q != StFull);
        end else begin
            in_ready = (state_q == StEmpty) || out_ready_i;
        end
        in_fire  = in_valid_i && in_ready;
        out_fire = (state_q != StEmpty) && out_ready_i;

        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush_i) begin
            state_d = StEmpty;
            main_d  = BUBBLE_VAL;
            skid_d  = BUBBLE_VAL;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        main_d  = in_data_i;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data_i;
                    end else if (in_fire) begin
                        skid_d  = in_data_i;
                        state_d = StFull;
                    end else if (out_fire) begin
                        main_d  = BUBBLE_VAL;
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        skid_d  = BUBBLE_VAL;
                        state_d = StOne;
                    end
                end
                default: begin
                    state_d = StEmpty;
                    main_d  = BUBBLE_VAL;
                    skid_d  = BUBBLE_VAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StEmpty;
            main_q  <= BUBBLE_VAL;
            skid_q  <= BUBBLE_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign in_ready_o  = in_ready;
    assign out_valid_o = (state_q != StEmpty);
    assign out_data_o  = main_q;
    assign occupancy_o = state_q;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer: a skid instance and a single-entry instance share stimulus;
// each is compared against an ordered-queue model, plus a directed table and corner sequences.
module tb_pipe_stage_buffer;

    localparam int unsigned DW = 96;
    localparam logic [DW-1:0] B1 = '0;
    localparam logic [DW-1:0] B0 = 96'h0bad_0000_0000_0000_0000_f00d;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          ir1, ov1, ir0, ov0;
    logic [DW-1:0] od1, od0;
    logic [1:0]    occ1, occ0;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] q1[$];
    logic [DW-1:0] q0[$];

    always #5 clk = ~clk;

    pipe_stage_buffer #(.DATA_W(DW), .BUBBLE_VAL(B1), .SKID_EN(1'b1)) u_skid (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir1),
        .in_data_i(in_data), .out_valid_o(ov1), .out_ready_i(out_ready), .out_data_o(od1),
        .occupancy_o(occ1)
    );

    pipe_stage_buffer #(.DATA_W(DW), .BUBBLE_VAL(B0), .SKID_EN(1'b0)) u_single (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir0),
        .in_data_i(in_data), .out_valid_o(ov0), .out_ready_i(out_ready), .out_data_o(od0),
        .occupancy_o(occ0)
    );

    typedef struct {
        logic          f;
        logic          v;
        logic [DW-1:0] d;
        logic          r;
        logic          ev;
        logic [DW-1:0] ed;
        logic [1:0]    eocc;
        logic          eir;
    } vec_t;

    vec_t tbl[18];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic f, input logic v, input logic [DW-1:0] d, input logic r);
        flush     = f;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
    endtask

    // Model: each stage is an ordered FIFO of capacity 2 (skid) or 1 (single).
    task automatic check_model();
        int unsigned s1 = q1.size();
        int unsigned s0 = q0.size();
        check("skid_valid", {95'd0, ov1}, {95'd0, s1 != 0});
        check("skid_data", od1, (s1 != 0) ? q1[0] : B1);
        check("skid_occ", {94'd0, occ1}, DW'(s1));
        check("skid_ready", {95'd0, ir1}, {95'd0, s1 < 2});
        check("single_valid", {95'd0, ov0}, {95'd0, s0 != 0});
        check("single_data", od0, (s0 != 0) ? q0[0] : B0);
        check("single_occ", {94'd0, occ0}, DW'(s0));
        check("single_ready", {95'd0, ir0}, {95'd0, (s0 == 0) || out_ready});
    endtask

    task automatic tick();
        logic in1, out1, in0, out0;
        in1  = in_valid && (q1.size() < 2);
        out1 = (q1.size() != 0) && out_ready;
        in0  = in_valid && ((q0.size() == 0) || out_ready);
        out0 = (q0.size() != 0) && out_ready;
        @(posedge clk);
        if (rst || flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (out1) void'(q1.pop_front());
            if (in1) q1.push_back(in_data);
            if (out0) void'(q0.pop_front());
            if (in0) q0.push_back(in_data);
        end
        @(negedge clk);
    endtask

    initial begin
        // Backpressure A,B,C; streaming 1..4; flush while FULL with C pending.
        tbl[0]  = '{1'b0, 1'b1, 96'hA, 1'b0, 1'b0, 96'h0, 2'd0, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 96'hB, 1'b0, 1'b1, 96'hA, 2'd1, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 96'hC, 1'b0, 1'b1, 96'hA, 2'd2, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 96'hC, 1'b1, 1'b1, 96'hA, 2'd2, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 96'hC, 1'b1, 1'b1, 96'hB, 2'd1, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 96'h0, 1'b1, 1'b1, 96'hC, 2'd1, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 96'h0, 1'b1, 1'b0, 96'h0, 2'd0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 96'h1, 1'b1, 1'b0, 96'h0, 2'd0, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 96'h2, 1'b1, 1'b1, 96'h1, 2'd1, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 96'h3, 1'b1, 1'b1, 96'h2, 2'd1, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 96'h4, 1'b1, 1'b1, 96'h3, 2'd1, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 96'h0, 1'b1, 1'b1, 96'h4, 2'd1, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 96'h0, 1'b0, 1'b0, 96'h0, 2'd0, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 96'hA, 1'b0, 1'b0, 96'h0, 2'd0, 1'b1};
        tbl[14] = '{1'b0, 1'b1, 96'hB, 1'b0, 1'b1, 96'hA, 2'd1, 1'b1};
        tbl[15] = '{1'b1, 1'b1, 96'hC, 1'b0, 1'b1, 96'hA, 2'd2, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 96'h0, 1'b1, 1'b0, 96'h0, 2'd0, 1'b1};
        tbl[17] = '{1'b0, 1'b0, 96'h0, 1'b1, 1'b0, 96'h0, 2'd0, 1'b1};

        rst = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0);
        check("rst_occ", {94'd0, occ1}, 96'd0);
        check("rst_ready", {95'd0, ir1}, 96'd1);
        check("rst_data1", od1, B1);
        check("rst_data0", od0, B0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].f, tbl[i].v, tbl[i].d, tbl[i].r);
            check($sformatf("tbl%0d_valid", i), {95'd0, ov1}, {95'd0, tbl[i].ev});
            check($sformatf("tbl%0d_data", i), od1, tbl[i].ed);
            check($sformatf("tbl%0d_occ", i), {94'd0, occ1}, {94'd0, tbl[i].eocc});
            check($sformatf("tbl%0d_ready", i), {95'd0, ir1}, {95'd0, tbl[i].eir});
            tick();
        end

        // Single-entry stage: ready follows out_ready combinationally while full.
        drive(1'b0, 1'b1, 96'h11, 1'b0);
        tick();
        drive(1'b0, 1'b1, 96'h22, 1'b0);
        check("single_full_valid", {95'd0, ov0}, 96'd1);
        check("single_blocked", {95'd0, ir0}, 96'd0);
        drive(1'b0, 1'b1, 96'h22, 1'b1);
        check("single_passthru", {95'd0, ir0}, 96'd1);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        check("single_replaced", od0, 96'h22);
        check("single_occ1", {94'd0, occ0}, 96'd1);
        drive(1'b1, 1'b0, '0, 1'b0);
        tick();

        // Asynchronous reset between edges while the skid stage is full.
        drive(1'b0, 1'b1, 96'h33, 1'b0);
        tick();
        drive(1'b0, 1'b1, 96'h44, 1'b0);
        tick();
        check("pre_rst_occ", {94'd0, occ1}, 96'd2);
        rst = 1'b1;
        #1;
        check("async_rst_valid", {95'd0, ov1}, 96'd0);
        check("async_rst_data", od1, B1);
        check("async_rst_occ", {94'd0, occ1}, 96'd0);
        check("async_rst_ready", {95'd0, ir1}, 96'd1);
        check("async_rst_single", od0, B0);
        rst = 1'b0;
        q1.delete();
        q0.delete();
        drive(1'b0, 1'b1, 96'h55, 1'b1);
        tick();
        drive(1'b0, 1'b0, '0, 1'b1);
        check("post_rst_data", od1, 96'h55);
        check("post_rst_single", od0, 96'h55);
        tick();

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(15) == 0), $urandom_range(1) == 1,
                  {$urandom(), $urandom(), $urandom()}, $urandom_range(3) != 0);
            check_model();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
- Parametrised successor to the fixed-width IF/ID pipeline latch.
- Generic DATA_W payload stage with valid/ready handshake, an optional 2-entry skid buffer and flush-to-bubble.
- Sits between any two CPU pipeline stages (IF/ID, ID/EX, ...).
- Replaces the write-enable stall with backpressure, so stalls never drop or duplicate an instruction.

Parameters:
- DATA_W, 96, payload width (e.g. address + instr + pc_add4).
- BUBBLE_VAL, {DATA_W{1'b0}}, value driven on out_data_o whenever the stage is empty.
- SKID_EN, 1: 1 gives a registered in_ready_o with 2 entries; 0 gives a single entry with combinational in_ready_o.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  discard all held entries; synchronous.
- in_valid_i  in  1  upstream has data.
- in_ready_o  out  1  stage can accept data this cycle.
- in_data_i  in  DATA_W  upstream payload.
- out_valid_o  out  1  out_data_o holds a valid entry.
- out_ready_i  in  1  downstream accepts this cycle.
- out_data_o  out  DATA_W  payload to next stage.
- occupancy_o  out  2  number of held entries (0..2).

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values, immediate and held while rst_i=1:
  - out_valid_o=0, out_data_o=BUBBLE_VAL, occupancy_o=0.
  - Skid valid=0, so in_ready_o=1 (SKID_EN=1).
- Handshakes:
  - in_fire = in_valid_i & in_ready_o.
  - out_fire = out_valid_o & out_ready_i.
  - Data must stay stable upstream while in_valid_i=1 and in_ready_o=0. The stage honours the same rule downstream.
- Latency and throughput: 1 cycle from in_fire to out_valid_o. Sustained throughput is 1 transfer/cycle when out_ready_i=1.
- SKID_EN=1: states EMPTY(0), ONE(1), FULL(2). in_ready_o = (state != FULL), a pure register output with no path from out_ready_i.
  - EMPTY:
    - in_fire: main<=in_data_i, go to ONE.
    - Otherwise hold.
  - ONE:
    - in_fire & out_fire: main<=in_data_i, stay in ONE.
    - in_fire only: skid<=in_data_i, go to FULL.
    - out_fire only: main<=BUBBLE_VAL, go to EMPTY.
    - Neither: hold.
  - FULL (no in_fire possible):
    - out_fire: main<=skid, go to ONE.
    - Otherwise hold.
- SKID_EN=0: states EMPTY and ONE only. in_ready_o = ~out_valid_o | out_ready_i (combinational). Same main-register rules as above; the FULL state is unreachable.
- Ordering: entries leave strictly in arrival order. The skid entry is always younger than main.
- flush_i=1 has priority over every handshake and returns the stage to EMPTY next edge:
  - out_valid_o<=0, out_data_o<=BUBBLE_VAL.
  - Skid entry discarded.
  - Any in_fire on that cycle is discarded.
  - in_ready_o=1 the next cycle.
- out_data_o equals BUBBLE_VAL whenever out_valid_o=0. A downstream stage that ignores valid still sees a NOP.
- occupancy_o mirrors the state encoding: EMPTY=0, ONE=1, FULL=2. The value 3 never occurs.
- Reset asserted mid-operation: every held entry is lost immediately, without waiting for a clock edge. The first accept is on the first clk_i edge after rst_i deasserts.
- flush_i and rst_i together: reset dominates.

Test Plan:
- Reset: rst_i=1 with out_valid/skid non-empty -> same delta cycle out_valid_o=0, out_data_o=BUBBLE_VAL (0), occupancy_o=0, in_ready_o=1.
- Streaming: in_valid_i=1 with payloads 1,2,3,4 on consecutive cycles, out_ready_i=1 -> out_data_o=1,2,3,4 one cycle later each, no gaps, occupancy_o=1 throughout.
- Backpressure (SKID_EN=1): out_ready_i=0 while pushing A,B,C ->
  - A and B accepted, occupancy_o=2, in_ready_o=0, C held upstream.
  - Release out_ready_i -> outputs A,B,C in order, no loss or duplication.
- Flush in FULL: occupancy_o=2 (A,B) and in_valid_i=1 (C) with flush_i=1 -> next cycle out_valid_o=0, out_data_o=BUBBLE_VAL, occupancy_o=0, C not delivered, in_ready_o=1.
- SKID_EN=0: out_valid_o=1, out_ready_i=0 -> in_ready_o=0. With out_ready_i=1 in the same cycle -> in_ready_o=1 and the new word replaces main next edge.
- Reset mid-stream: pulse rst_i between clock edges while occupancy_o=2 -> outputs clear immediately. First accepted word after release appears at out_data_o one cycle later.
